// File: rtl/axis_out_packer_if.sv
// Element-in / AXI-Stream-out signal bundle for axis_out_packer.
// master is the packer's view, slave is the view of the surrounding logic.
interface axis_out_packer_if #(
  parameter int IN_WIDTH             = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
);
  logic                                in_valid;
  logic                                in_ready;
  logic [IN_WIDTH-1:0]                 in_data;
  logic                                in_last;
  logic                                M_AXIS_TVALID;
  logic                                M_AXIS_TREADY;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP;
  logic                                M_AXIS_TLAST;

  modport master (
    input  in_valid, in_data, in_last, M_AXIS_TREADY,
    output in_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
  );

  modport slave (
    output in_valid, in_data, in_last, M_AXIS_TREADY,
    input  in_ready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_out_packer.sv
// Requantises psum elements, packs them into AXI-Stream beats and buffers beats in a FWFT FIFO.
// Optional macro OUT_PACKER_RELU_EN: clamp negative requantised values to zero before saturation.
module axis_out_packer #(
  parameter int IN_WIDTH             = 16,
  parameter int ELEM_WIDTH           = 8,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 8,
  parameter int SHIFT_WIDTH          = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [SHIFT_WIDTH-1:0]        requant_shift,
  axis_out_packer_if.master             bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          layer_done
);
  localparam int EPB     = C_M_AXIS_TDATA_WIDTH / ELEM_WIDTH;
  localparam int KEEP_W  = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int BPE     = ELEM_WIDTH / 8;
  localparam int LANE_W  = (EPB > 1) ? $clog2(EPB) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = C_M_AXIS_TDATA_WIDTH + KEEP_W + 1;
  localparam logic signed [IN_WIDTH-1:0] MAX_V =
    {{(IN_WIDTH-ELEM_WIDTH+1){1'b0}}, {(ELEM_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [IN_WIDTH-1:0] requant(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]     sh
  );
    logic signed [IN_WIDTH-1:0] r;
    r = x >>> sh;
`ifdef OUT_PACKER_RELU_EN
    if (r < 0) r = '0;
`endif
    return r;
  endfunction

  function automatic logic clamps(input logic signed [IN_WIDTH-1:0] x);
    return (x > MAX_V) || (x < MIN_V);
  endfunction

  function automatic logic signed [ELEM_WIDTH-1:0] saturate(input logic signed [IN_WIDTH-1:0] x);
    if (x > MAX_V) return ELEM_WIDTH'(MAX_V);
    if (x < MIN_V) return ELEM_WIDTH'(MIN_V);
    return x[ELEM_WIDTH-1:0];
  endfunction

  logic [ENTRY_W-1:0]                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                  wr_ptr, rd_ptr;
  logic [PTR_W:0]                    count;
  logic [LANE_W-1:0]                 lane;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   pack_p0;
  logic signed [IN_WIDTH-1:0]        shifted;
  logic signed [ELEM_WIDTH-1:0]      elem;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   beat_data;
  logic [KEEP_W-1:0]                 beat_keep;
  logic                              fifo_full, fifo_empty, accept, push, pop;

  assign fifo_full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign bus.in_ready = ~fifo_full;
  assign accept       = bus.in_valid & ~fifo_full & ~clear;
  assign push         = accept & ((lane == LANE_W'(EPB-1)) | bus.in_last);
  assign pop          = ~fifo_empty & bus.M_AXIS_TREADY & ~clear;
  assign shifted      = requant($signed(bus.in_data), requant_shift);
  assign elem         = saturate(shifted);

  // Beat as it would look with the current element merged in; unfilled lanes stay zero.
  always_comb begin
    beat_data = pack_p0;
    beat_data[int'(lane)*ELEM_WIDTH +: ELEM_WIDTH] = elem;
    beat_keep = '0;
    for (int b = 0; b < KEEP_W; b++) beat_keep[b] = ((b / BPE) <= int'(lane));
  end

  // Head entry is masked while empty so the idle bus reads as zero.
  assign bus.M_AXIS_TVALID = ~fifo_empty;
  assign {bus.M_AXIS_TLAST, bus.M_AXIS_TKEEP, bus.M_AXIS_TDATA} =
    fifo_empty ? '0 : mem[rd_ptr];
  assign fifo_level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      pack_p0    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sat_flag   <= 1'b0;
      layer_done <= 1'b0;
    end else if (clear) begin
      lane       <= '0;
      pack_p0    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sat_flag   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= pop & mem[rd_ptr][ENTRY_W-1];
      if (accept) begin
        if (clamps(shifted)) sat_flag <= 1'b1;
        if (push) begin
          lane    <= '0;
          pack_p0 <= '0;
        end else begin
          lane    <= lane + 1'b1;
          pack_p0 <= beat_data;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_last, beat_keep, beat_data};
  end
endmodule

// File: tb/tb_axis_out_packer.sv
// Bench for axis_out_packer: constant vector table plus model-driven streams, beats checked via a scoreboard queue.
module tb_axis_out_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [4:0] shift = '0;
  logic [3:0] fifo_level;
  logic       sat_flag, layer_done;

  axis_out_packer_if #(.IN_WIDTH(16), .C_M_AXIS_TDATA_WIDTH(32)) bus();

  axis_out_packer dut (
    .clk(clk), .rst(rst), .clear(clear), .requant_shift(shift), .bus(bus),
    .fifo_level(fifo_level), .sat_flag(sat_flag), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int               sh;
    logic [3:0][15:0] d;
    int               n;
    bit               last;
    logic [31:0]      ed;
    logic [3:0]       ek;
    bit               es;
  } vec_t;

  beat_t       sb[$];
  vec_t        vt[8];
  int          tests = 0;
  int          fails = 0;
  int          m_lane = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_keep = '0;
  bit          ld_exp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int sh, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [15:0] d, int n, bit last, logic [31:0] ed,
                              logic [3:0] ek, bit es);
    vec_t v;
    v.sh = sh; v.d = {d, c, b, a}; v.n = n; v.last = last;
    v.ed = ed; v.ek = ek; v.es = es;
    return v;
  endfunction

  function automatic logic [7:0] model_q(logic [15:0] d, int sh);
    int v;
    v = $signed(d);
    v = v >>> sh;
`ifdef OUT_PACKER_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    sb.push_back(b);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l);
    int  n = 0;
    bit  acc;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 2000);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_m(input logic [15:0] d, input logic l);
    m_data[m_lane*8 +: 8] = model_q(d, int'(shift));
    m_keep[m_lane] = 1'b1;
    if (m_lane == 3 || l) begin
      expect_beat(m_data, m_keep, l);
      m_lane = 0; m_data = '0; m_keep = '0;
    end else m_lane++;
    send(d, l);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.M_AXIS_TVALID) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'(sb.size() != 0 || bus.M_AXIS_TVALID), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    m_lane = 0; m_data = '0; m_keep = '0;
  endtask

  // Monitor: handshakes are judged half a cycle before the edge that completes them.
  always @(negedge clk) begin
    beat_t e;
    if (rst) ld_exp = 1'b0;
    else begin
      if (ld_exp || layer_done) chk("layer_done", 64'(layer_done), 64'(ld_exp));
      ld_exp = 1'b0;
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && !clear) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %h, expected none", bus.M_AXIS_TDATA);
        end else begin
          e = sb.pop_front();
          chk("tdata", 64'(bus.M_AXIS_TDATA), 64'(e.data));
          chk("tkeep", 64'(bus.M_AXIS_TKEEP), 64'(e.keep));
          chk("tlast", 64'(bus.M_AXIS_TLAST), 64'(e.last));
          ld_exp = bus.M_AXIS_TLAST;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.M_AXIS_TREADY = 1'b0;

`ifdef OUT_PACKER_RELU_EN
    vt[3] = mk(0, 16'h7FFF, 16'h8000, 16'hFFF0, 16'h0005, 4, 0, 32'h0500007F, 4'hF, 1);
    vt[5] = mk(8, 16'h1234, 16'hFF00, 16'h7FFF, 16'h8000, 4, 1, 32'h007F0012, 4'hF, 1);
    vt[6] = mk(31, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 4, 0, 32'h00000000, 4'hF, 1);
    vt[7] = mk(2, 16'h0100, 16'h0200, 16'hFE00, 16'hFDFC, 4, 1, 32'h00007F40, 4'hF, 1);
`else
    vt[3] = mk(0, 16'h7FFF, 16'h8000, 16'hFFF0, 16'h0005, 4, 0, 32'h05F0807F, 4'hF, 1);
    vt[5] = mk(8, 16'h1234, 16'hFF00, 16'h7FFF, 16'h8000, 4, 1, 32'h807FFF12, 4'hF, 1);
    vt[6] = mk(31, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 4, 0, 32'hFF0000FF, 4'hF, 1);
    vt[7] = mk(2, 16'h0100, 16'h0200, 16'hFE00, 16'hFDFC, 4, 1, 32'h80807F40, 4'hF, 1);
`endif
    vt[0] = mk(4, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 4, 0, 32'h04030201, 4'hF, 0);
    vt[1] = mk(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4, 0, 32'h04030201, 4'hF, 0);
    vt[2] = mk(0, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 2, 1, 32'h00000605, 4'h3, 0);
    vt[4] = mk(0, 16'h0009, 16'h0000, 16'h0000, 16'h0000, 1, 1, 32'h00000009, 4'h1, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    chk("rst_layer_done", 64'(layer_done), 64'd0);
    chk("rst_bus", 64'({bus.M_AXIS_TDATA, bus.M_AXIS_TKEEP, bus.M_AXIS_TLAST}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table
    bus.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      shift = 5'(vt[i].sh);
      expect_beat(vt[i].ed, vt[i].ek, vt[i].last);
      for (int k = 0; k < vt[i].n; k++) send(vt[i].d[k], vt[i].last && (k == vt[i].n - 1));
      wait_drain();
      chk($sformatf("vec%0d_sat", i), 64'(sat_flag), 64'(vt[i].es));
    end

    // Latency: beat visible the cycle after its completing element
    do_clear();
    bus.M_AXIS_TREADY = 1'b0; shift = 5'd0;
    expect_beat(32'h0C0B0A09, 4'hF, 1'b0);
    send(16'h0009, 0); send(16'h000A, 0); send(16'h000B, 0);
    chk("lat_tvalid_before", 64'(bus.M_AXIS_TVALID), 64'd0);
    send(16'h000C, 0);
    chk("lat_tvalid_after", 64'(bus.M_AXIS_TVALID), 64'd1);
    chk("lat_level", 64'(fifo_level), 64'd1);
    bus.M_AXIS_TREADY = 1'b1;
    wait_drain();

    // Backpressure: 32 accepts fill the FIFO, then drain one beat per cycle
    do_clear();
    bus.M_AXIS_TREADY = 1'b0; shift = 5'd3;
    for (int i = 0; i < 32; i++) send_m(16'($urandom), 0);
    chk("bp_level_full", 64'(fifo_level), 64'd8);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = 16'h0077;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_level_hold", 64'(fifo_level), 64'd8);
    bus.M_AXIS_TREADY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp_drain%0d", k), 64'(bus.M_AXIS_TVALID), 64'd1);
    end
    @(posedge clk); #1;
    chk("bp_empty", 64'(bus.M_AXIS_TVALID), 64'd0);
    for (int i = 0; i < 8; i++) send_m(16'($urandom), i == 7);
    wait_drain();

    // Push and pop in the same cycle
    do_clear();
    bus.M_AXIS_TREADY = 1'b0; shift = 5'd0;
    for (int i = 0; i < 12; i++) send_m(16'(i * 3 + 1), 0);
    chk("pp_level_start", 64'(fifo_level), 64'd3);
    for (int j = 0; j < 16; j++) begin
      bus.M_AXIS_TREADY = ((j % 4) == 3);
      send_m(16'($urandom_range(0, 255)), 0);
      chk($sformatf("pp_level%0d", j), 64'(fifo_level), 64'd3);
    end
    bus.M_AXIS_TREADY = 1'b1;
    wait_drain();

    // Asynchronous reset in the middle of a beat
    do_clear();
    send(16'h7FFF, 0); send(16'h0001, 0);
    chk("mid_sat_before", 64'(sat_flag), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_sat", 64'(sat_flag), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_beat(32'h14131211, 4'hF, 1'b0);
    send(16'h0011, 0); send(16'h0012, 0); send(16'h0013, 0); send(16'h0014, 0);
    wait_drain();

    // Clear with five queued beats, plus an element offered during clear
    bus.M_AXIS_TREADY = 1'b0;
    send_m(16'h7FFF, 0);
    for (int i = 1; i < 20; i++) send_m(16'(i), 0);
    chk("clr_level_before", 64'(fifo_level), 64'd5);
    chk("clr_sat_before", 64'(sat_flag), 64'd1);
    bus.in_valid = 1'b1; bus.in_data = 16'h0055;
    do_clear();
    bus.in_valid = 1'b0;
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_tvalid", 64'(bus.M_AXIS_TVALID), 64'd0);
    chk("clr_sat", 64'(sat_flag), 64'd0);
    bus.M_AXIS_TREADY = 1'b1;
    expect_beat(32'h04030201, 4'hF, 1'b0);
    send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 0); send(16'h0004, 0);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
